// File: rtl/dllp_acknak_rx.sv
// dllp_acknak_rx: assembles 3-word Ack/Nak DLLPs, checks CRC-16, filters
// stale/duplicate sequence numbers and hands results to the replay buffer,
// holding one result pending while the replay buffer is busy.
// Optional statistics counters are enabled by defining DLLP_ACKNAK_STATS_EN.
module dllp_acknak_rx #(
  parameter logic [7:0] ACK_TYPE = 8'h00,
  parameter logic [7:0] NAK_TYPE = 8'h10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dllp_valid,
  input  logic        dllp_sof,
  input  logic [15:0] dllp_data,
  input  logic [11:0] next_tx_seq,
  input  logic        busy_n,
  output logic [1:0]  ack_nack,
  output logic [11:0] seq,
  output logic        crc_err
`ifdef DLLP_ACKNAK_STATS_EN
  ,
  output logic [15:0] stat_crc_err,
  output logic [15:0] stat_drop,
  output logic [15:0] stat_ovwr
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_W1, S_W2} state_t;

  state_t      r_state, w_state_next;
  logic [7:0]  r_type;
  logic [11:0] r_seq_rx;
  logic [15:0] r_crc;
  logic [11:0] r_acked;
  logic        r_pend;
  logic        r_pend_nak;
  logic [11:0] r_pend_seq;
  logic [1:0]  r_an;
  logic [11:0] r_seq;
  logic        r_crc_err;

  // One 16-bit MSB-first step of the CRC, polynomial 0x100B.
  function automatic logic [15:0] f_crc_step(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] v;
    v = c;
    for (int i = 15; i >= 0; i--) begin
      if (v[15] ^ d[i]) v = {v[14:0], 1'b0} ^ 16'h100B;
      else              v = {v[14:0], 1'b0};
    end
    return v;
  endfunction

  logic [15:0] w_crc_step;
  logic        w_w2;
  logic        w_crc_ok;
  logic        w_is_ack;
  logic        w_is_nak;
  logic [11:0] w_d_ack;
  logic [11:0] w_d_out;
  logic        w_accept;
  logic        w_new;
  logic        w_ovwr;

  // A new frame restarts the CRC from all-ones; otherwise continue the running value.
  assign w_crc_step = f_crc_step(dllp_sof ? 16'hFFFF : r_crc, dllp_data);
  assign w_w2       = dllp_valid & ~dllp_sof & (r_state == S_W2);
  assign w_crc_ok   = (dllp_data == ~r_crc);
  assign w_is_ack   = (r_type == ACK_TYPE);
  assign w_is_nak   = (r_type == NAK_TYPE);
  // Modular distance of the received seq and of the newest outstanding seq from the last acked one.
  assign w_d_ack    = r_seq_rx - r_acked;
  assign w_d_out    = next_tx_seq - 12'd1 - r_acked;
  assign w_accept   = (w_d_ack <= w_d_out) & (w_is_nak | (w_d_ack != 12'd0));
  assign w_new      = w_w2 & w_crc_ok & (w_is_ack | w_is_nak) & w_accept;
  assign w_ovwr     = w_new & ~busy_n & r_pend;

  // Frame-word state register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state: sof always restarts at W1; gaps hold; stray words in IDLE are ignored.
  always_comb begin
    w_state_next = r_state;
    if (dllp_valid && dllp_sof) begin
      w_state_next = S_W1;
    end else if (dllp_valid) begin
      case (r_state)
        S_W1:    w_state_next = S_W2;
        S_W2:    w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Frame capture, CRC accumulation, sequence tracking and result issue/pending.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_type     <= 8'h00;
      r_seq_rx   <= 12'h000;
      r_crc      <= 16'hFFFF;
      r_acked    <= 12'hFFF;
      r_pend     <= 1'b0;
      r_pend_nak <= 1'b0;
      r_pend_seq <= 12'h000;
      r_an       <= 2'b00;
      r_seq      <= 12'h000;
      r_crc_err  <= 1'b0;
    end else begin
      r_an      <= 2'b00;
      r_crc_err <= 1'b0;
      if (dllp_valid && dllp_sof) begin
        r_type <= dllp_data[15:8];
        r_crc  <= w_crc_step;
      end else if (dllp_valid && r_state == S_W1) begin
        r_seq_rx <= dllp_data[11:0];
        r_crc    <= w_crc_step;
      end
      if (w_w2 && !w_crc_ok) r_crc_err <= 1'b1;
      if (w_new) begin
        r_acked <= r_seq_rx;
        if (busy_n) begin
          // New result takes the output even if a pending one drains this cycle.
          r_an   <= w_is_nak ? 2'b10 : 2'b01;
          r_seq  <= r_seq_rx;
          r_pend <= 1'b0;
        end else begin
          r_pend     <= 1'b1;
          r_pend_seq <= r_seq_rx;
          // A pending Nak is sticky against later Acks.
          r_pend_nak <= w_is_nak | (r_pend & r_pend_nak);
        end
      end else if (r_pend && busy_n) begin
        r_an   <= r_pend_nak ? 2'b10 : 2'b01;
        r_seq  <= r_pend_seq;
        r_pend <= 1'b0;
      end
    end
  end

  assign ack_nack = r_an;
  assign seq      = r_seq;
  assign crc_err  = r_crc_err;

`ifdef DLLP_ACKNAK_STATS_EN
  logic [15:0] r_stat_crc;
  logic [15:0] r_stat_drop;
  logic [15:0] r_stat_ovwr;
  logic        w_drop;

  assign w_drop = w_w2 & w_crc_ok & ~w_new;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stat_crc  <= 16'h0000;
      r_stat_drop <= 16'h0000;
      r_stat_ovwr <= 16'h0000;
    end else begin
      if (w_w2 && !w_crc_ok && r_stat_crc  != 16'hFFFF) r_stat_crc  <= r_stat_crc + 16'd1;
      if (w_drop            && r_stat_drop != 16'hFFFF) r_stat_drop <= r_stat_drop + 16'd1;
      if (w_ovwr            && r_stat_ovwr != 16'hFFFF) r_stat_ovwr <= r_stat_ovwr + 16'd1;
    end
  end

  assign stat_crc_err = r_stat_crc;
  assign stat_drop    = r_stat_drop;
  assign stat_ovwr    = r_stat_ovwr;
`else
  logic w_unused_ovwr;
  assign w_unused_ovwr = w_ovwr;
`endif

endmodule

// File: tb/tb_dllp_acknak_rx.sv
// tb_dllp_acknak_rx: scoreboard bench for dllp_acknak_rx. Expected results
// are queued when a frame's last word (or a busy release) is driven and
// compared when the DUT pulses ack_nack or crc_err.
module tb_dllp_acknak_rx;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        dllp_valid;
  logic        dllp_sof;
  logic [15:0] dllp_data;
  logic [11:0] next_tx_seq;
  logic        busy_n;
  logic [1:0]  ack_nack;
  logic [11:0] seq;
  logic        crc_err;
`ifdef DLLP_ACKNAK_STATS_EN
  logic [15:0] stat_crc_err, stat_drop, stat_ovwr;
`endif

  dllp_acknak_rx dut (
    .clk(clk), .reset_n(reset_n), .dllp_valid(dllp_valid), .dllp_sof(dllp_sof),
    .dllp_data(dllp_data), .next_tx_seq(next_tx_seq), .busy_n(busy_n),
    .ack_nack(ack_nack), .seq(seq), .crc_err(crc_err)
`ifdef DLLP_ACKNAK_STATS_EN
    , .stat_crc_err(stat_crc_err), .stat_drop(stat_drop), .stat_ovwr(stat_ovwr)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  an;
    logic [11:0] sq;
    logic        ce;
    int          due;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  // Reference CRC: serial over the 32 message bits, returns the W2 field.
  function automatic logic [15:0] crc_field(input logic [31:0] m);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 31; i >= 0; i--) c = (c[15] ^ m[i]) ? ((c << 1) ^ 16'h100B) : (c << 1);
    return ~c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic sof, input logic [15:0] d);
    dllp_valid = 1'b1;
    dllp_sof   = sof;
    dllp_data  = d;
    tick();
    dllp_valid = 1'b0;
    dllp_sof   = 1'b0;
  endtask

  task automatic push(input logic [1:0] an, input logic [11:0] sq, input logic ce);
    exp_t e;
    e.an = an; e.sq = sq; e.ce = ce; e.due = cyc + 1;
    sb.push_back(e);
  endtask

  // Sends a full frame; exp_an/exp_ce both zero means no output is expected.
  task automatic send(input logic [7:0] typ, input logic [11:0] sq, input logic [15:0] flip,
                      input logic [1:0] exp_an, input logic [11:0] exp_sq, input logic exp_ce);
    logic [15:0] w0, w1;
    w0 = {typ, 8'h00};
    w1 = {4'h0, sq};
    drive_word(1'b1, w0);
    drive_word(1'b0, w1);
    if (exp_an != 2'b00 || exp_ce) push(exp_an, exp_sq, exp_ce);
    drive_word(1'b0, crc_field({w0, w1}) ^ flip);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    tick();
    tick();
    check({tag, "_rst_an"},  ack_nack, 0);
    check({tag, "_rst_seq"}, seq, 0);
    check({tag, "_rst_ce"},  crc_err, 0);
    reset_n = 1'b1;
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && (ack_nack != 2'b00 || crc_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_out", {ack_nack, seq, crc_err}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_nack", ack_nack, e.an);
        check("seq",      seq,      e.sq);
        check("crc_err",  crc_err,  e.ce);
        check("latency",  cyc,      e.due);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; dllp_valid = 1'b0; dllp_sof = 1'b0; dllp_data = 16'h0;
    next_tx_seq = 12'd5; busy_n = 1'b1;
    tick();
    do_reset("t0");

    // 1: good Ack seq=3
    send(8'h00, 12'd3, 16'h0, 2'b01, 12'd3, 1'b0);
    tick();
    // 2: W2 bit 0 flipped -> crc_err only, seq holds 3
    send(8'h00, 12'd3, 16'h1, 2'b00, 12'd3, 1'b1);
    tick();
    // acked still 3: Ack 4 accepted (d_ack=1, d_out=1)
    send(8'h00, 12'd4, 16'h0, 2'b01, 12'd4, 1'b0);
    // unknown type with good CRC is dropped
    send(8'h20, 12'd4, 16'h0, 2'b00, 12'd0, 1'b0);
    tick();

    // 3: pending overwrite, Nak wins
    do_reset("t3");
    busy_n = 1'b0;
    send(8'h00, 12'd1, 16'h0, 2'b00, 12'd0, 1'b0);
    send(8'h10, 12'd2, 16'h0, 2'b00, 12'd0, 1'b0);
    // Ack while Nak pending must not demote it (acked=2, Ack 3 ok, d_out=2)
    send(8'h00, 12'd3, 16'h0, 2'b00, 12'd0, 1'b0);
    tick();
    push(2'b10, 12'd3, 1'b0);
    busy_n = 1'b1;
    tick();
    tick();
`ifdef DLLP_ACKNAK_STATS_EN
    check("stat_ovwr", stat_ovwr, 2);
`endif

    // 4: from acked=3 move to acked=10, then dup/ahead filters
    next_tx_seq = 12'd12;
    send(8'h00, 12'd10, 16'h0, 2'b01, 12'd10, 1'b0);
    send(8'h00, 12'd10, 16'h0, 2'b00, 12'd0, 1'b0);
    send(8'h00, 12'd20, 16'h0, 2'b00, 12'd0, 1'b0);
    send(8'h10, 12'd10, 16'h0, 2'b10, 12'd10, 1'b0);
    tick();
`ifdef DLLP_ACKNAK_STATS_EN
    check("stat_drop", stat_drop, 2);
`endif

    // 5: wrap
    next_tx_seq = 12'd4095;
    send(8'h00, 12'd4094, 16'h0, 2'b01, 12'd4094, 1'b0);
    next_tx_seq = 12'd3;
    send(8'h00, 12'd1, 16'h0, 2'b01, 12'd1, 1'b0);
    tick();

    // 6: sof restart after W1, with a gap inside the second frame
    next_tx_seq = 12'd10;
    drive_word(1'b1, 16'h1000);
    drive_word(1'b0, 16'h0005);
    drive_word(1'b1, 16'h0000);
    drive_word(1'b0, 16'h0007);
    tick();
    push(2'b01, 12'd7, 1'b0);
    drive_word(1'b0, crc_field({16'h0000, 16'h0007}));
    tick();
    // stray non-sof word in IDLE is ignored
    drive_word(1'b0, 16'h1234);
    tick();

    // reset during the frame: nothing reported
    drive_word(1'b1, 16'h0000);
    drive_word(1'b0, 16'h0008);
    reset_n = 1'b0;
    drive_word(1'b0, crc_field({16'h0000, 16'h0008}));
    tick();
    check("midrst_an",  ack_nack, 0);
    check("midrst_seq", seq, 0);
    reset_n = 1'b1;
    tick();
    // acked back to 0xFFF: Ack 0 accepted
    next_tx_seq = 12'd5;
    send(8'h00, 12'd0, 16'h0, 2'b01, 12'd0, 1'b0);

    repeat (5) tick();
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
